// File: rtl/calc_pkg.sv
// Shared definitions for the calculator self-test driver:
// ALU opcodes, vector record layout, default vector ROM, FSM encodings.
package calc_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] exp;
    } vec_t;

    localparam int unsigned ROM_DEPTH = 16;

    // Shifts move a by b[2:0]; NOT ignores b.
    localparam vec_t VEC_ROM [ROM_DEPTH] = '{
        '{8'h05, 8'h03, OP_ADD, 8'h08},
        '{8'h07, 8'h05, OP_SUB, 8'h02},
        '{8'hF0, 8'h3C, OP_AND, 8'h30},
        '{8'hF0, 8'h0F, OP_OR,  8'hFF},
        '{8'hAA, 8'hFF, OP_XOR, 8'h55},
        '{8'h03, 8'h02, OP_SHL, 8'h0C},
        '{8'h80, 8'h03, OP_SHR, 8'h10},
        '{8'h5A, 8'h00, OP_NOT, 8'hA5},
        '{8'hFF, 8'h01, OP_ADD, 8'h00},
        '{8'h00, 8'h01, OP_SUB, 8'hFF},
        '{8'h12, 8'h34, OP_ADD, 8'h46},
        '{8'hC3, 8'h3C, OP_XOR, 8'hFF},
        '{8'h0F, 8'hF0, OP_AND, 8'h00},
        '{8'h01, 8'h07, OP_SHL, 8'h80},
        '{8'hFF, 8'h04, OP_SHR, 8'h0F},
        '{8'h00, 8'h00, OP_NOT, 8'hFF}
    };

    localparam logic [4:0] FAIL_MAX = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } top_state_t;

    typedef enum logic [2:0] {
        STEP_CLEAR,
        STEP_LOAD_A,
        STEP_LOAD_B,
        STEP_LOAD_OP,
        STEP_CHECK,
        STEP_CMP
    } step_t;

    typedef enum logic [1:0] {
        P_IDLE,
        P_SETUP,
        P_PRESS,
        P_RELEASE
    } press_state_t;

endpackage

// File: rtl/calc_autotest_driver_if.sv
// Calculator-side bus of the self-test driver: switches, buttons
// and the ALU result coming back.
interface calc_autotest_driver_if;

    logic [7:0] sw_out;
    logic       btnL_out;
    logic       btnR_out;
    logic [7:0] result;

    modport master (
        output sw_out,
        output btnL_out,
        output btnR_out,
        input  result
    );

    modport slave (
        input  sw_out,
        input  btnL_out,
        input  btnR_out,
        output result
    );

endinterface

// File: rtl/press_gen.sv
// SETUP/PRESS/RELEASE button timer; press_done marks the last
// RELEASE cycle so a chained request starts SETUP without a gap.
module press_gen
    import calc_pkg::*;
#(
    parameter int unsigned PRESS_CYCLES = 2_500_000,
    parameter int unsigned GAP_CYCLES   = 2_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic sel_l,
    output logic btn_l,
    output logic btn_r,
    output logic press_done
);

    press_state_t st_q, st_d;
    logic [31:0]  cnt_q, cnt_d;
    logic         sel_q, sel_d;
    logic         btn_l_q, btn_l_d;
    logic         btn_r_q, btn_r_d;
    logic         done_q, done_d;

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        sel_d = sel_q;
        unique case (st_q)
            P_IDLE: begin
                if (req) begin
                    st_d  = P_SETUP;
                    cnt_d = GAP_CYCLES - 1;
                    sel_d = sel_l;
                end
            end
            P_SETUP: begin
                if (cnt_q == 32'd0) begin
                    st_d  = P_PRESS;
                    cnt_d = PRESS_CYCLES - 1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            P_PRESS: begin
                if (cnt_q == 32'd0) begin
                    st_d  = P_RELEASE;
                    cnt_d = GAP_CYCLES - 1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            P_RELEASE: begin
                if (cnt_q == 32'd0) begin
                    if (req) begin
                        st_d  = P_SETUP;
                        cnt_d = GAP_CYCLES - 1;
                        sel_d = sel_l;
                    end else begin
                        st_d = P_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: st_d = P_IDLE;
        endcase
        btn_l_d = (st_d == P_PRESS) && sel_d;
        btn_r_d = (st_d == P_PRESS) && !sel_d;
        done_d  = (st_d == P_RELEASE) && (cnt_d == 32'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= P_IDLE;
            cnt_q   <= 32'd0;
            sel_q   <= 1'b0;
            btn_l_q <= 1'b0;
            btn_r_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            btn_l_q <= btn_l_d;
            btn_r_q <= btn_r_d;
            done_q  <= done_d;
        end
    end

    assign btn_l      = btn_l_q;
    assign btn_r      = btn_r_q;
    assign press_done = done_q;

endmodule

// File: rtl/calc_autotest_driver.sv
// Built-in self-test initiator: replays the vector ROM into the
// calculator as button presses and counts mismatching results.
module calc_autotest_driver
    import calc_pkg::*;
#(
    parameter int unsigned PRESS_CYCLES = 2_500_000,
    parameter int unsigned GAP_CYCLES   = 2_500_000,
    parameter int unsigned NUM_VEC      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    calc_autotest_driver_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [4:0]            fail_cnt,
    output logic [3:0]            vec_idx
);

    localparam logic [3:0] LAST_VEC = 4'(NUM_VEC - 1);

    top_state_t  st_q, st_d;
    step_t       step_q, step_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  sw_q, sw_d;
    logic [7:0]  res_q, res_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [4:0]  fail_q, fail_d;
    logic [3:0]  vec_q, vec_d;
    logic        start_s1_q, start_s1_d;
    logic        start_s2_q, start_s2_d;
    logic        rise;
    logic        req, sel_l, press_done;
    vec_t        cur;

    assign rise = start_s1_q & ~start_s2_q;

    always_comb begin
        st_d       = st_q;
        step_d     = step_q;
        cnt_d      = cnt_q;
        sw_d       = sw_q;
        res_d      = res_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        vec_d      = vec_q;
        start_s1_d = start;
        start_s2_d = start_s1_q;
        req        = 1'b0;
        sel_l      = 1'b0;
        cur        = VEC_ROM[vec_q];
        unique case (st_q)
            ST_RUN: begin
                unique case (step_q)
                    STEP_CLEAR: begin
                        if (press_done) begin
                            step_d = STEP_LOAD_A;
                            sw_d   = cur.a;
                            req    = 1'b1;
                        end
                    end
                    STEP_LOAD_A: begin
                        if (press_done) begin
                            step_d = STEP_LOAD_B;
                            sw_d   = cur.b;
                            req    = 1'b1;
                        end
                    end
                    STEP_LOAD_B: begin
                        if (press_done) begin
                            step_d = STEP_LOAD_OP;
                            sw_d   = {5'b0, cur.op};
                            req    = 1'b1;
                        end
                    end
                    STEP_LOAD_OP: begin
                        if (press_done) begin
                            step_d = STEP_CHECK;
                            cnt_d  = GAP_CYCLES - 1;
                        end
                    end
                    STEP_CHECK: begin
                        if (cnt_q == 32'd0) begin
                            step_d = STEP_CMP;
                            res_d  = bus.result;
                        end else begin
                            cnt_d = cnt_q - 32'd1;
                        end
                    end
                    STEP_CMP: begin
                        if (res_q != cur.exp && fail_q != FAIL_MAX)
                            fail_d = fail_q + 5'd1;
                        if (vec_q == LAST_VEC) begin
                            st_d   = ST_DONE;
                            busy_d = 1'b0;
                            done_d = 1'b1;
                            pass_d = (fail_d == 5'd0);
                        end else begin
                            vec_d  = vec_q + 4'd1;
                            step_d = STEP_CLEAR;
                            sw_d   = 8'd0;
                            req    = 1'b1;
                            sel_l  = 1'b1;
                        end
                    end
                    default: step_d = STEP_CLEAR;
                endcase
            end
            // IDLE and DONE both wait for an accepted start edge
            default: begin
                if (rise) begin
                    st_d   = ST_RUN;
                    step_d = STEP_CLEAR;
                    busy_d = 1'b1;
                    done_d = 1'b0;
                    pass_d = 1'b0;
                    fail_d = 5'd0;
                    vec_d  = 4'd0;
                    sw_d   = 8'd0;
                    req    = 1'b1;
                    sel_l  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= ST_IDLE;
            step_q     <= STEP_CLEAR;
            cnt_q      <= 32'd0;
            sw_q       <= 8'd0;
            res_q      <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 5'd0;
            vec_q      <= 4'd0;
            start_s1_q <= 1'b0;
            start_s2_q <= 1'b0;
        end else begin
            st_q       <= st_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            sw_q       <= sw_d;
            res_q      <= res_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            vec_q      <= vec_d;
            start_s1_q <= start_s1_d;
            start_s2_q <= start_s2_d;
        end
    end

    press_gen #(
        .PRESS_CYCLES(PRESS_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES)
    ) u_press_gen (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .sel_l     (sel_l),
        .btn_l     (bus.btnL_out),
        .btn_r     (bus.btnR_out),
        .press_done(press_done)
    );

    assign bus.sw_out = sw_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_cnt   = fail_q;
    assign vec_idx    = vec_q;

endmodule

// File: tb/tb_calc_autotest_driver.sv
// Bench for calc_autotest_driver: two instances (3 and 16 vectors)
// driven against a behavioural calculator model.
module tb_calc_autotest_driver;
    import calc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;

    always #5 clk = ~clk;

    calc_autotest_driver_if ifa ();
    calc_autotest_driver_if ifb ();

    logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [4:0] fail_a, fail_b;
    logic [3:0] vec_a, vec_b;

    calc_autotest_driver #(
        .PRESS_CYCLES(4), .GAP_CYCLES(3), .NUM_VEC(3)
    ) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bus(ifa),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .fail_cnt(fail_a), .vec_idx(vec_a)
    );

    calc_autotest_driver #(
        .PRESS_CYCLES(4), .GAP_CYCLES(3), .NUM_VEC(16)
    ) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bus(ifb),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .fail_cnt(fail_b), .vec_idx(vec_b)
    );

    logic [7:0] sw_w [2];
    logic       btnl_w [2], btnr_w [2];
    logic       busy_w [2], done_w [2], pass_w [2];
    logic [4:0] fail_w [2];
    logic [3:0] vec_w [2];
    logic [7:0] res_v [2];

    assign sw_w[0] = ifa.sw_out;    assign sw_w[1] = ifb.sw_out;
    assign btnl_w[0] = ifa.btnL_out; assign btnl_w[1] = ifb.btnL_out;
    assign btnr_w[0] = ifa.btnR_out; assign btnr_w[1] = ifb.btnR_out;
    assign busy_w[0] = busy_a; assign busy_w[1] = busy_b;
    assign done_w[0] = done_a; assign done_w[1] = done_b;
    assign pass_w[0] = pass_a; assign pass_w[1] = pass_b;
    assign fail_w[0] = fail_a; assign fail_w[1] = fail_b;
    assign vec_w[0] = vec_a;   assign vec_w[1] = vec_b;
    assign ifa.result = res_v[0];
    assign ifb.result = res_v[1];

    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SHL:  return a << b[2:0];
            OP_SHR:  return a >> b[2:0];
            default: return ~a;
        endcase
    endfunction

    // calculator model and pulse monitor state, per instance
    logic [7:0] ma [2], mb [2];
    logic [2:0] mo [2];
    int mcnt [2], mvec [2], mode_v [2];
    logic pbusy [2], pl [2], pr [2], bh1 [2], bh2 [2], bh3 [2];
    logic [7:0] sw1 [2], sw2 [2], sw3 [2];
    int blen [2], lcnt [2], rcnt [2], ovl [2], wbad [2], sbad [2], hl [2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            res_v[i] = alu(ma[i], mb[i], mo[i]);
            if (mode_v[i] == 1 && mvec[i] == 1) res_v[i] = 8'h00;
            else if (mode_v[i] == 2) res_v[i] = res_v[i] ^ 8'hFF;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            pbusy[i] <= busy_w[i];
            pl[i] <= btnl_w[i];
            pr[i] <= btnr_w[i];
            sw1[i] <= sw_w[i]; sw2[i] <= sw1[i]; sw3[i] <= sw2[i];
            bh1[i] <= btnl_w[i] | btnr_w[i];
            bh2[i] <= bh1[i]; bh3[i] <= bh2[i];
            hl[i] <= (btnl_w[i] | btnr_w[i]) ? (bh1[i] ? hl[i] + 1 : 1) : 0;
            if (busy_w[i] && !pbusy[i]) begin
                blen[i] <= 1; lcnt[i] <= 0; rcnt[i] <= 0;
                ovl[i] <= 0; wbad[i] <= 0; sbad[i] <= 0; mvec[i] <= -1;
            end else begin
                if (busy_w[i]) blen[i] <= blen[i] + 1;
                if (btnl_w[i] && !pl[i]) begin
                    lcnt[i] <= lcnt[i] + 1;
                    mvec[i] <= mvec[i] + 1;
                    mcnt[i] <= 0;
                end
                if (btnr_w[i] && !pr[i]) begin
                    rcnt[i] <= rcnt[i] + 1;
                    mcnt[i] <= mcnt[i] + 1;
                    case (mcnt[i])
                        0: ma[i] <= sw_w[i];
                        1: mb[i] <= sw_w[i];
                        default: mo[i] <= sw_w[i][2:0];
                    endcase
                end
                if (btnl_w[i] && btnr_w[i]) ovl[i] <= ovl[i] + 1;
                if (!(btnl_w[i] | btnr_w[i]) && bh1[i] && hl[i] != 4)
                    wbad[i] <= wbad[i] + 1;
                if ((btnl_w[i] | btnr_w[i]) && !bh1[i] &&
                    !(sw_w[i] == sw1[i] && sw_w[i] == sw2[i] && sw_w[i] == sw3[i]))
                    sbad[i] <= sbad[i] + 1;
                if (sw_w[i] != sw1[i] &&
                    (btnl_w[i] || btnr_w[i] || bh1[i] || bh2[i] || bh3[i]))
                    sbad[i] <= sbad[i] + 1;
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_start(input int d, input logic v);
        if (d == 0) start_a = v;
        else start_b = v;
    endtask

    task automatic start_seq(input int d);
        @(negedge clk);
        set_start(d, 1'b1);
        @(posedge clk); #1;
        chk("start_lat0", int'(busy_w[d]), 0);
        @(posedge clk); #1;
        chk("start_lat1", int'(busy_w[d]), 1);
        chk("fail_clr", int'(fail_w[d]), 0);
        chk("done_clr", int'(done_w[d]), 0);
        chk("vec_clr", int'(vec_w[d]), 0);
        @(negedge clk);
        set_start(d, 1'b0);
    endtask

    typedef struct {
        int dut;
        int mode;
        int poke;
        int efail;
        int epass;
        int evec;
        int nvec;
    } run_t;

    task automatic do_run(input run_t r);
        int d;
        d = r.dut;
        mode_v[d] = r.mode;
        start_seq(d);
        if (r.poke != 0) begin
            repeat (20) @(negedge clk);
            set_start(d, 1'b1);
            repeat (2) @(negedge clk);
            set_start(d, 1'b0);
        end
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (done_w[d]) break;
        end
        chk("done", int'(done_w[d]), 1);
        chk("busy_end", int'(busy_w[d]), 0);
        chk("pass", int'(pass_w[d]), r.epass);
        chk("fail_cnt", int'(fail_w[d]), r.efail);
        chk("vec_idx", int'(vec_w[d]), r.evec);
        chk("run_len", blen[d], r.nvec * 44);
        chk("btnL_pulses", lcnt[d], r.nvec);
        chk("btnR_pulses", rcnt[d], 3 * r.nvec);
        chk("btn_overlap", ovl[d], 0);
        chk("pulse_width", wbad[d], 0);
        chk("sw_stable", sbad[d], 0);
    endtask

    run_t tbl [5];
    run_t rr;

    initial begin
        tbl[0] = '{0, 0, 1, 0, 1, 2, 3};
        tbl[1] = '{0, 1, 0, 1, 0, 2, 3};
        tbl[2] = '{1, 2, 0, 16, 0, 15, 16};
        tbl[3] = '{1, 2, 0, 16, 0, 15, 16};
        tbl[4] = '{1, 0, 0, 0, 1, 15, 16};
        mode_v[0] = 0;
        mode_v[1] = 0;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_sw", int'(sw_w[i]), 0);
            chk("rst_btnL", int'(btnl_w[i]), 0);
            chk("rst_btnR", int'(btnr_w[i]), 0);
            chk("rst_busy", int'(busy_w[i]), 0);
            chk("rst_done", int'(done_w[i]), 0);
            chk("rst_pass", int'(pass_w[i]), 0);
            chk("rst_fail", int'(fail_w[i]), 0);
            chk("rst_vec", int'(vec_w[i]), 0);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int k = 0; k < 5; k++) do_run(tbl[k]);

        // reset during the step-2 press, then restart from scratch
        mode_v[0] = 0;
        start_seq(0);
        for (int c = 0; c < 300; c++) begin
            if (rcnt[0] == 2 && btnr_w[0]) break;
            @(negedge clk);
        end
        chk("reach_step2", int'(rcnt[0] == 2 && btnr_w[0]), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_btnR", int'(btnr_w[0]), 0);
        chk("mid_rst_btnL", int'(btnl_w[0]), 0);
        chk("mid_rst_sw", int'(sw_w[0]), 0);
        chk("mid_rst_busy", int'(busy_w[0]), 0);
        chk("mid_rst_vec", int'(vec_w[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rr = '{0, 0, 0, 0, 1, 2, 3};
        do_run(rr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc_autotest_driver.md
# calc_autotest_driver

Built-in self-test initiator for the 8-bit calculator. It replays a fixed vector list into the calculator's operand-entry state machine. For each vector it emits the same debounced-length button presses and switch values a user would produce, then samples the displayed ALU result and compares it with the stored expected value. It sits between the board inputs and the calculator's `sw`/`btnL`/`btnR` inputs, selected by a mux in the top level, and reports pass/fail on LEDs.

## Interface
- `PRESS_CYCLES`, default 2_500_000 — cycles a generated button is held high (25 ms at 100 MHz); must exceed debouncer settle time.
- `GAP_CYCLES`, default 2_500_000 — cycles buttons are held low before each press, after each release, and before the result sample.
- `NUM_VEC`, default 8 — number of vectors in the ROM (1..16).
- `clk` input 1 — system clock.
- `rst` input 1 — synchronous, active-high reset.
- `start` input 1 — level; its rising edge (detected internally) begins a run when idle.
- `result` input 8 — calculator ALU result, low byte of the display value.
- `sw_out` output 8 — switch value presented to the calculator.
- `btnL_out` output 1 — generated clear press.
- `btnR_out` output 1 — generated advance press.
- `busy` output 1 — high from the accepted start until the run finishes.
- `done` output 1 — high after a run completes; cleared by the next accepted start or by reset.
- `pass` output 1 — valid while `done`; high iff `fail_cnt == 0`.
- `fail_cnt` output 5 — number of mismatching vectors in the current or last run, saturating at 31.
- `vec_idx` output 4 — index of the vector in progress, or of the last vector after `done`.

## Operation
- Vector ROM entry: {a[7:0], b[7:0], op[2:0], exp[7:0]}.
- Each vector runs 5 steps in order:
  - 0 CLEAR: `sw_out`=0, press `btnL_out`.
  - 1 LOAD_A: `sw_out`=a, press `btnR_out`.
  - 2 LOAD_B: `sw_out`=b, press `btnR_out`.
  - 3 LOAD_OP: `sw_out`={5'b0,op}, press `btnR_out`.
  - 4 CHECK: wait GAP_CYCLES, then sample `result` once; if it differs from exp, increment `fail_cnt` (saturating).
- Press sub-FSM for steps 0–3: SETUP (`sw_out` updated, buttons low, GAP_CYCLES) → PRESS (selected button high, PRESS_CYCLES) → RELEASE (buttons low, GAP_CYCLES) → next step.
- `sw_out` holds its value from SETUP through the end of RELEASE.
- Top FSM states: IDLE → RUN (steps/sub-states as above) → DONE.
- After CHECK of vector NUM_VEC-1 → DONE. Otherwise increment `vec_idx` and return to step 0.
- DONE persists until the next `start` rising edge, which clears `fail_cnt`, sets `vec_idx`=0 and enters RUN.
- A `start` edge while busy is ignored.
- Only one button is ever high at a time. Both buttons are never high in the same cycle.

## Timing
- Reset values: `sw_out`=0, `btnL_out`=0, `btnR_out`=0, `busy`=0, `done`=0, `pass`=0, `fail_cnt`=0, `vec_idx`=0; state IDLE; cycle counter 0.
- `start` edge detection: a rise sampled at edge k sets `busy` at edge k+1, and SETUP of step 0 begins then.
- Each delay state lasts exactly its parameter count in cycles. The counter reloads on every state entry.
- Per-vector length: 4·(2·GAP_CYCLES + PRESS_CYCLES) + GAP_CYCLES + 1 cycles, the +1 being the compare cycle.
- `result` is sampled on the last cycle of the CHECK wait. The compare registers on the following edge, and on that same edge `vec_idx` advances or DONE is entered.
- In DONE, `busy`=0 and `done`=1 on the same edge.
- `rst` asserted mid-run: on the next edge every output returns to its reset value, and any button in progress drops low.

## Structure
- `calc_pkg`: ALU opcode constants (OP_ADD=3'b000, OP_SUB=3'b001, OP_AND=3'b010, OP_OR=3'b011, OP_XOR=3'b100, OP_SHL=3'b101, OP_SHR=3'b110, OP_NOT=3'b111), the vector record layout, the default vector ROM constant, and step/state encodings.
- Sub-module `press_gen`: the SETUP/PRESS/RELEASE timer. It takes a request pulse plus button select and returns a one-cycle `press_done`.

## Test plan
- Short timing (PRESS_CYCLES=4, GAP_CYCLES=3). Vector {a=0x05, b=0x03, OP_ADD, exp=0x08} with `result` tied to a bench calculator model → `done`=1, `pass`=1, `fail_cnt`=0. Check `btnR_out` high pulses are exactly 4 cycles wide with `sw_out` stable 3 cycles either side.
- NUM_VEC=3, bench forces `result`=0x00 on vector 1 (exp 0x02) → `fail_cnt`=1, `pass`=0, `vec_idx`=2 at `done`.
- Force mismatches on all vectors with NUM_VEC=16, run twice without reset → `fail_cnt` is 16 after each run (cleared on start), never wrapping.
- Assert `rst` for one cycle during the PRESS of step 2 → next edge: `btnR_out`=0, `sw_out`=0, `busy`=0. A new `start` restarts at vector 0 step 0.
- Pulse `start` while busy → ignored. Total run length equals NUM_VEC × (4·(2·3+4)+3+1) = NUM_VEC × 44 cycles.
- Assertion over all runs: `btnL_out` & `btnR_out` never both 1. Exactly one `btnL_out` pulse and three `btnR_out` pulses per vector.
